fsgn_arbiter: RTL

- Shares one registered sign-injection datapath (fsgnj / fsgnjn / fsgnjx) between two requesters, e.g. the main FPU issue path and a second issue slot.
- Arbitrates round-robin, computes the result bitwise, and holds it in a single output register with a valid/ready handshake toward writeback.
- Pure bit manipulation: no float arithmetic, no exception flags, and −0 / NaN / denormal operands pass through with only bit 31 affected.

---
 rtl/fsgn_arbiter_if.sv | 37 +++
 rtl/fsgn_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/fsgn_arbiter_if.sv
// fsgn_arbiter_if: two request channels and one result channel of the sign-injection arbiter
interface fsgn_arbiter_if #(parameter int TAG_W = 5);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [31:0]      req0_x1;
    logic [31:0]      req0_x2;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [31:0]      req1_x1;
    logic [31:0]      req1_x2;
    logic [TAG_W-1:0] req1_tag;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_y;
    logic [TAG_W-1:0] res_tag;
    logic             res_src;
    logic             res_illegal;

    modport master (
        output req0_valid, req0_op, req0_x1, req0_x2, req0_tag,
        output req1_valid, req1_op, req1_x1, req1_x2, req1_tag,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_y, res_tag, res_src, res_illegal
    );

    modport slave (
        input  req0_valid, req0_op, req0_x1, req0_x2, req0_tag,
        input  req1_valid, req1_op, req1_x1, req1_x2, req1_tag,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_y, res_tag, res_src, res_illegal
    );
endinterface

// File: rtl/fsgn_arbiter.sv
// fsgn_arbiter: round-robin shared fsgnj/fsgnjn/fsgnjx unit with one registered result slot.
// Optional per-requester accept counters are built when FSGN_ARB_CNT_EN is defined.
module fsgn_arbiter #(parameter int TAG_W = 5) (
    input logic          clk,
    input logic          rstn,
`ifdef FSGN_ARB_CNT_EN
    input  logic         cnt_clr,
    output logic [31:0]  cnt0,
    output logic [31:0]  cnt1,
`endif
    fsgn_arbiter_if.slave bus
);
    logic             last_grant;
    logic             slot_free;
    logic             g0;
    logic             g1;
    logic             acc;
    logic [1:0]       sel_op;
    logic [31:0]      sel_x1;
    logic [31:0]      sel_x2;
    logic [TAG_W-1:0] sel_tag;
    logic             res_valid;
    logic [31:0]      res_y;
    logic [TAG_W-1:0] res_tag;
    logic             res_src;
    logic             res_illegal;

    // Only bit 31 is computed; op 11 leaves x1 untouched
    function automatic logic [31:0] sgn(input logic [1:0] op, input logic [31:0] x1, input logic [31:0] x2);
        return {op == 2'b00 ? x2[31] : op == 2'b01 ? ~x2[31] : op == 2'b10 ? x1[31] ^ x2[31] : x1[31], x1[30:0]};
    endfunction

    // The slot can refill in the same cycle it drains; a contended grant goes to the requester that did not win last
    assign slot_free = !res_valid || bus.res_ready;
    assign g0 = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign g1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
    assign bus.req0_ready = rstn && slot_free && g0;
    assign bus.req1_ready = rstn && slot_free && g1;
    assign acc = bus.req0_ready || bus.req1_ready;
    assign sel_op = bus.req1_ready ? bus.req1_op : bus.req0_op;
    assign sel_x1 = bus.req1_ready ? bus.req1_x1 : bus.req0_x1;
    assign sel_x2 = bus.req1_ready ? bus.req1_x2 : bus.req0_x2;
    assign sel_tag = bus.req1_ready ? bus.req1_tag : bus.req0_tag;
    assign bus.res_valid = res_valid;
    assign bus.res_y = res_y;
    assign bus.res_tag = res_tag;
    assign bus.res_src = res_src;
    assign bus.res_illegal = res_illegal;

    // Result register: load on accept, clear valid on a drain with no refill
    always_ff @(posedge clk) begin
        if (!rstn) begin
            res_valid   <= 1'b0;
            res_y       <= '0;
            res_tag     <= '0;
            res_src     <= 1'b0;
            res_illegal <= 1'b0;
            last_grant  <= 1'b1;
        end else if (acc) begin
            res_valid   <= 1'b1;
            res_y       <= sgn(sel_op, sel_x1, sel_x2);
            res_tag     <= sel_tag;
            res_src     <= bus.req1_ready;
            res_illegal <= sel_op == 2'b11;
            last_grant  <= bus.req1_ready;
        end else if (bus.res_ready) begin
            res_valid   <= 1'b0;
        end
    end

`ifdef FSGN_ARB_CNT_EN
    // Accept counters; clear wins over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rstn || cnt_clr) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            cnt0 <= cnt0 + {31'd0, bus.req0_ready};
            cnt1 <= cnt1 + {31'd0, bus.req1_ready};
        end
    end
`endif
endmodule
